// File: rtl/bus_share_arb_pkg.sv
// Shared types and constants for the four-way round-robin bus sharing arbiter.
// Bus word layout: tag in the low TAG_W bits, requester data above it.
package bus_share_pkg;

   localparam int unsigned N_REQ     = 4;
   localparam int unsigned DATA_W    = 10;
   localparam int unsigned TAG_W     = $clog2(N_REQ);
   localparam int unsigned BUS_W     = DATA_W + TAG_W;
   localparam int unsigned MAX_BURST = 4;
   localparam int unsigned STALL_MAX = 8;
   localparam int unsigned BEAT_W    = $clog2(MAX_BURST + 1);
   localparam int unsigned STALL_W   = $clog2(STALL_MAX + 1);
   localparam int unsigned TAG_LSB   = 0;
   localparam int unsigned DATA_LSB  = TAG_W;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } bus_word_t;

   function automatic logic [BUS_W-1:0] pack_word(input logic [DATA_W-1:0] data,
                                                  input logic [TAG_W-1:0]  tag);
      bus_word_t w;
      w.data = data;
      w.tag  = tag;
      return w;
   endfunction

   function automatic logic [TAG_W-1:0] word_tag(input logic [BUS_W-1:0] w);
      return w[TAG_LSB +: TAG_W];
   endfunction

   function automatic logic [DATA_W-1:0] word_data(input logic [BUS_W-1:0] w);
      return w[DATA_LSB +: DATA_W];
   endfunction

endpackage

// File: rtl/bus_share_arb_if.sv
// Requester bundles, downstream bus and status of the bus sharing arbiter.
// slave = arbiter side, master = requesters plus downstream consumer.
interface bus_share_arb_if;
   import bus_share_pkg::*;

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_last;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    bus_valid;
   logic [BUS_W-1:0]        bus_word;
   logic                    bus_ready;
   logic [N_REQ-1:0]        grant;
   logic                    busy;

   modport slave (
      input  req_valid, req_last, req_data, bus_ready,
      output req_ready, bus_valid, bus_word, grant, busy
   );

   modport master (
      output req_valid, req_last, req_data, bus_ready,
      input  req_ready, bus_valid, bus_word, grant, busy
   );

endinterface

// File: rtl/bus_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after last_i+1,
// wrapping. One-hot output is zero when no request is set.
module rr_pick
   import bus_share_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [TAG_W-1:0] last_i,
   output logic [N_REQ-1:0] pick_oh_c_o,
   output logic [TAG_W-1:0] pick_idx_c_o
);

   logic [TAG_W-1:0] cand;

   // Walk from the farthest candidate back to the nearest so the nearest wins.
   always_comb begin
      pick_idx_c_o = '0;
      cand         = '0;
      for (int k = int'(N_REQ); k > 0; k--) begin
         cand = TAG_W'((int'(last_i) + k) % int'(N_REQ));
         if (req_i[cand]) pick_idx_c_o = cand;
      end
      pick_oh_c_o = (|req_i) ? (N_REQ'(1) << pick_idx_c_o) : '0;
   end

endmodule

// File: rtl/bus_share_arb.sv
// Round-robin arbiter granting one of four requesters a burst on the shared
// tagged bus; bursts end on last, on the beat limit, or on a stall timeout.
module bus_share_arb
   import bus_share_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   bus_share_arb_if.slave bus_if
);

   state_e             state_q, state_d;
   logic [TAG_W-1:0]   owner_q, owner_d;
   logic [TAG_W-1:0]   last_owner_q, last_owner_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [STALL_W-1:0] stall_q, stall_d;

   logic [N_REQ-1:0]   pick_oh;
   logic [TAG_W-1:0]   pick_idx;
   logic [DATA_W-1:0]  req_data_arr [N_REQ];
   logic               xfer;
   logic               own_valid;
   logic               own_last;
   logic               beat;
   logic [BEAT_W-1:0]  beat_inc;
   logic [STALL_W-1:0] stall_inc;

   for (genvar r = 0; r < N_REQ; r++) begin : g_data
      assign req_data_arr[r] = bus_if.req_data[r*DATA_W +: DATA_W];
   end

   rr_pick u_pick (
      .req_i        (bus_if.req_valid),
      .last_i       (last_owner_q),
      .pick_oh_c_o  (pick_oh),
      .pick_idx_c_o (pick_idx)
   );

   assign xfer      = (state_q == XFER);
   assign own_valid = bus_if.req_valid[owner_q];
   assign own_last  = bus_if.req_last[owner_q];
   assign beat      = xfer & own_valid & bus_if.bus_ready;
   assign beat_inc  = beat_q + BEAT_W'(1);
   assign stall_inc = stall_q + STALL_W'(1);

   // Output mux driven from the registered owner; grant_q is zero in IDLE.
   assign bus_if.grant     = grant_q;
   assign bus_if.busy      = xfer;
   assign bus_if.bus_valid = xfer & own_valid;
   assign bus_if.bus_word  = xfer ? pack_word(req_data_arr[owner_q], owner_q) : '0;
   assign bus_if.req_ready = grant_q & {N_REQ{bus_if.bus_ready}};

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      grant_d      = grant_q;
      beat_d       = beat_q;
      stall_d      = stall_q;
      unique case (state_q)
         IDLE: begin
            if (|bus_if.req_valid) begin
               state_d = XFER;
               owner_d = pick_idx;
               grant_d = pick_oh;
               beat_d  = '0;
               stall_d = '0;
            end
         end
         XFER: begin
            if (beat) begin
               beat_d  = beat_inc;
               stall_d = '0;
               if (own_last || (beat_inc == BEAT_W'(MAX_BURST))) begin
                  state_d      = IDLE;
                  grant_d      = '0;
                  last_owner_d = owner_q;
               end
            end else if (!own_valid) begin
               stall_d = stall_inc;
               // Revoke once the owner has been silent for STALL_MAX cycles.
               if (stall_inc == STALL_W'(STALL_MAX)) begin
                  state_d      = IDLE;
                  grant_d      = '0;
                  last_owner_d = owner_q;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= TAG_W'(N_REQ - 1);
         grant_q      <= '0;
         beat_q       <= '0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         grant_q      <= grant_d;
         beat_q       <= beat_d;
         stall_q      <= stall_d;
      end
   end

endmodule

// File: tb/tb_bus_share_arb.sv
// Bench for bus_share_arb: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the arbitration rules.
module tb_bus_share_arb;
   import bus_share_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   logic [DATA_W-1:0] d [N_REQ];

   bus_share_arb_if bif ();

   bus_share_arb dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bif)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic drive_data();
      for (int r = 0; r < int'(N_REQ); r++) bif.req_data[r*DATA_W +: DATA_W] = d[r];
   endtask

   task automatic idle_inputs();
      bif.req_valid = '0;
      bif.req_last  = '0;
      bif.bus_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      for (int r = 0; r < int'(N_REQ); r++) d[r] = DATA_W'($urandom);
      drive_data();
      #12;
      bif.req_valid = '1;
      bif.bus_ready = 1'b1;
      @(posedge clk);
      #2;
      total++;
      if ({bif.grant, bif.busy, bif.bus_valid} !== 6'b0) begin
         bad++;
         $display("FAIL reset_status: got %b want 000000", {bif.grant, bif.busy, bif.bus_valid});
      end
      total++;
      if ({bif.req_ready, bif.bus_word} !== 16'h0) begin
         bad++;
         $display("FAIL reset_bus: got %h want 0000", {bif.req_ready, bif.bus_word});
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle_inputs();
   endtask

   task automatic test_single();
      do_reset();
      bif.req_valid = 4'b0100;
      bif.bus_ready = 1'b1;
      d[2] = DATA_W'($urandom);
      drive_data();
      #1;
      total++;
      if (bif.grant !== 4'b0000) begin
         bad++;
         $display("FAIL single_pre_grant: got %b want 0000", bif.grant);
      end
      @(negedge clk);
      for (int w = 0; w < 3; w++) begin
         d[2] = DATA_W'($urandom);
         drive_data();
         bif.req_last = (w == 2) ? 4'b0100 : 4'b0000;
         #1;
         total++;
         if ({bif.grant, bif.req_ready, bif.bus_valid, bif.bus_word} !==
             {4'b0100, 4'b0100, 1'b1, d[2], 2'b10}) begin
            bad++;
            $display("FAIL single_beat%0d: got %h want %h", w,
                     {bif.grant, bif.req_ready, bif.bus_valid, bif.bus_word},
                     {4'b0100, 4'b0100, 1'b1, d[2], 2'b10});
         end
         @(negedge clk);
      end
      bif.req_valid = '0;
      bif.req_last  = '0;
      #1;
      total++;
      if ({bif.busy, bif.grant} !== 5'b0) begin
         bad++;
         $display("FAIL single_end_idle: got %b want 00000", {bif.busy, bif.grant});
      end
   endtask

   task automatic test_round_robin();
      int               order [6] = '{0, 1, 2, 3, 0, 0};
      int               g;
      logic [N_REQ-1:0] exp_g;
      do_reset();
      for (int r = 0; r < int'(N_REQ); r++) d[r] = DATA_W'($urandom);
      drive_data();
      bif.req_valid = '1;
      bif.bus_ready = 1'b1;
      for (int c = 0; c <= 25; c++) begin
         g = order[c/5];
         if (c % 5 == 0) exp_g = '0;
         else            exp_g = N_REQ'(1) << g;
         #1;
         total++;
         if (bif.grant !== exp_g) begin
            bad++;
            $display("FAIL rr_grant c=%0d: got %b want %b", c, bif.grant, exp_g);
         end
         if (exp_g != '0) begin
            total++;
            if (word_tag(bif.bus_word) !== TAG_W'(g) || word_data(bif.bus_word) !== d[g]) begin
               bad++;
               $display("FAIL rr_word c=%0d: got %h want %h", c, bif.bus_word, {d[g], TAG_W'(g)});
            end
         end
         @(negedge clk);
         if (exp_g != '0) begin
            d[g] = DATA_W'($urandom);
            drive_data();
         end
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      bif.req_valid = 4'b0010;
      bif.bus_ready = 1'b0;
      d[1] = DATA_W'($urandom);
      drive_data();
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         #1;
         total++;
         if ({bif.grant, bif.bus_valid, bif.req_ready, bif.bus_word} !==
             {4'b0010, 1'b1, 4'b0000, d[1], 2'b01}) begin
            bad++;
            $display("FAIL bp_hold i=%0d: got %h want %h", i,
                     {bif.grant, bif.bus_valid, bif.req_ready, bif.bus_word},
                     {4'b0010, 1'b1, 4'b0000, d[1], 2'b01});
         end
         @(negedge clk);
      end
      bif.bus_ready = 1'b1;
      bif.req_last  = 4'b0010;
      #1;
      total++;
      if (bif.req_ready !== 4'b0010) begin
         bad++;
         $display("FAIL bp_resume_ready: got %b want 0010", bif.req_ready);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      total++;
      if (bif.busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_end_idle: got %b want 0", bif.busy);
      end
   endtask

   task automatic test_stall();
      int beats = 0;
      do_reset();
      bif.req_valid = 4'b1000;
      bif.bus_ready = 1'b1;
      drive_data();
      @(negedge clk);
      bif.req_valid = 4'b0001;
      for (int i = 1; i <= int'(STALL_MAX); i++) begin
         #1;
         if (bif.bus_valid && bif.bus_ready) beats++;
         total++;
         if ({bif.grant, bif.bus_valid} !== 5'b10000) begin
            bad++;
            $display("FAIL stall_hold i=%0d: got %b want 10000", i, {bif.grant, bif.bus_valid});
         end
         @(negedge clk);
      end
      #1;
      total++;
      if ({bif.grant, bif.busy} !== 5'b0 || beats != 0) begin
         bad++;
         $display("FAIL stall_revoke: got %b beats=%0d want 00000 beats=0", {bif.grant, bif.busy}, beats);
      end
      @(negedge clk);
      #1;
      total++;
      if (bif.grant !== 4'b0001) begin
         bad++;
         $display("FAIL stall_next_winner: got %b want 0001", bif.grant);
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      do_reset();
      bif.req_valid = 4'b0001;
      bif.bus_ready = 1'b1;
      d[0] = DATA_W'($urandom);
      drive_data();
      repeat (3) @(negedge clk);
      #1;
      total++;
      if (bif.grant !== 4'b0001) begin
         bad++;
         $display("FAIL arst_pre: got %b want 0001", bif.grant);
      end
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({bif.grant, bif.busy, bif.bus_valid, bif.req_ready, bif.bus_word} !== 22'h0) begin
         bad++;
         $display("FAIL arst_outputs: got %h want 000000",
                  {bif.grant, bif.busy, bif.bus_valid, bif.req_ready, bif.bus_word});
      end
      @(negedge clk);
      rst_n = 1'b1;
      bif.req_valid = 4'b1001;
      #1;
      total++;
      if (bif.grant !== 4'b0000) begin
         bad++;
         $display("FAIL arst_release_idle: got %b want 0000", bif.grant);
      end
      @(negedge clk);
      #1;
      total++;
      if (bif.grant !== 4'b0001) begin
         bad++;
         $display("FAIL arst_first_winner: got %b want 0001", bif.grant);
      end
      idle_inputs();
   endtask

   task automatic test_alternate();
      logic [N_REQ-1:0] exp_g;
      do_reset();
      bif.req_valid = 4'b0011;
      bif.req_last  = 4'b0011;
      bif.bus_ready = 1'b1;
      drive_data();
      for (int c = 0; c < 8; c++) begin
         if (c % 2 == 0)      exp_g = 4'b0000;
         else if (c % 4 == 1) exp_g = 4'b0001;
         else                 exp_g = 4'b0010;
         #1;
         total++;
         if (bif.grant !== exp_g) begin
            bad++;
            $display("FAIL alt_grant c=%0d: got %b want %b", c, bif.grant, exp_g);
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      bit               m_busy   = 1'b0;
      int               m_owner  = 0;
      int               m_last   = int'(N_REQ) - 1;
      int               m_beats  = 0;
      int               m_stalls = 0;
      logic [N_REQ-1:0] v   = '0;
      logic [N_REQ-1:0] l   = '0;
      logic [N_REQ-1:0] acc = '0;
      logic             br;
      logic [N_REQ-1:0] eg, er;
      logic             ebv;
      logic [BUS_W-1:0] ew;
      int               r;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         br = ($urandom_range(0, 99) < 70);
         for (int q = 0; q < int'(N_REQ); q++) begin
            // A waiting, ungranted requester must keep presenting its word.
            if (!(v[q] && !acc[q] && !(m_busy && m_owner == q))) begin
               v[q] = ($urandom_range(0, 99) < ((m_busy && m_owner == q) ? 60 : 40));
               d[q] = DATA_W'($urandom);
               l[q] = ($urandom_range(0, 3) == 0);
            end
         end
         bif.req_valid = v;
         bif.req_last  = l;
         bif.bus_ready = br;
         drive_data();
         #1;
         if (m_busy) begin
            eg  = N_REQ'(1) << m_owner;
            ebv = v[m_owner];
            ew  = {d[m_owner], TAG_W'(m_owner)};
            er  = br ? eg : '0;
         end else begin
            eg = '0; ebv = 1'b0; ew = '0; er = '0;
         end
         total++;
         if ({bif.grant, bif.busy, bif.bus_valid, bif.req_ready, bif.bus_word} !==
             {eg, m_busy, ebv, er, ew}) begin
            bad++;
            $display("FAIL rand cyc=%0d: got %h want %h", cyc,
                     {bif.grant, bif.busy, bif.bus_valid, bif.req_ready, bif.bus_word},
                     {eg, m_busy, ebv, er, ew});
         end
         acc = er & v;
         if (!m_busy) begin
            if (|v) begin
               for (int i = int'(N_REQ); i >= 1; i--) begin
                  r = (m_last + i) % int'(N_REQ);
                  if (v[r]) m_owner = r;
               end
               m_busy   = 1'b1;
               m_beats  = 0;
               m_stalls = 0;
            end
         end else if (v[m_owner] && br) begin
            m_beats++;
            m_stalls = 0;
            if (l[m_owner] || m_beats == int'(MAX_BURST)) begin
               m_busy = 1'b0;
               m_last = m_owner;
            end
         end else if (!v[m_owner]) begin
            m_stalls++;
            if (m_stalls == int'(STALL_MAX)) begin
               m_busy = 1'b0;
               m_last = m_owner;
            end
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_stall();
      test_async_reset();
      test_alternate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
